// File: rtl/uart_rx_fifo.sv
// 8N1 oversampling UART receiver with a small first-word-fall-through receive FIFO.
// A 16x baud tick drives the frame FSM; accepted bytes are offered through a read strobe.
module uart_rx_fifo #(
    parameter int DBITS      = 8,
    parameter int SB_TICK    = 16,
    parameter int CLOCK_RATE = 100000000,
    parameter int BAUD_RATE  = 9600,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          PCLK,
    input  logic                          PRESET,
    input  logic                          rx,
    input  logic                          PREAD,
    input  logic                          clr_err,
    output logic [DBITS-1:0]              rx_dout,
    output logic                          rx_valid,
    output logic                          rx_done,
    output logic                          frame_err,
    output logic                          overrun,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int DIV  = CLOCK_RATE / (BAUD_RATE * 16);
    localparam int DIVW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int SW   = (SB_TICK > 16) ? $clog2(SB_TICK) : 4;
    localparam int NW   = (DBITS > 1) ? $clog2(DBITS) : 1;
    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int CW   = AW + 1;

    localparam logic [DIVW-1:0] DIV_LAST  = DIVW'(DIV - 1);
    localparam logic [SW-1:0]   START_MID = SW'(7);
    localparam logic [SW-1:0]   DATA_LAST = SW'(15);
    localparam logic [SW-1:0]   STOP_LAST = SW'(SB_TICK - 1);
    localparam logic [NW-1:0]   N_LAST    = NW'(DBITS - 1);
    localparam logic [CW-1:0]   DEPTH_C   = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    logic              sync1_q, sync2_q, prev_q;
    logic              start_edge_s;
    logic [DIVW-1:0]   tick_cnt_q, tick_cnt_d;
    logic              tick_s;
    state_t            state_q, state_d;
    logic [SW-1:0]     s_cnt_q, s_cnt_d;
    logic [NW-1:0]     n_q, n_d;
    logic [DBITS-1:0]  shreg_q, shreg_d;
    logic              push_s, ferr_set_s;
    logic [DBITS-1:0]  mem_q [FIFO_DEPTH];
    logic [AW-1:0]     wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              empty_s, full_s, pop_s, wr_s, ovr_set_s;
    logic              done_q, ferr_q, ferr_d, ovr_q, ovr_d;

    // Two-flop synchroniser plus a previous-sample flop for falling-edge detection.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
        end else begin
            sync1_q <= rx;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    assign start_edge_s = (state_q == S_IDLE) && prev_q && !sync2_q;

    // Oversample tick divider, re-phased to the start edge.
    always_comb begin
        tick_s     = (tick_cnt_q == DIV_LAST);
        tick_cnt_d = tick_cnt_q + DIVW'(1);
        if (start_edge_s) begin
            tick_cnt_d = '0;
        end else if (tick_s) begin
            tick_cnt_d = '0;
        end else begin
            tick_cnt_d = tick_cnt_q + DIVW'(1);
        end
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            tick_cnt_q <= '0;
        end else begin
            tick_cnt_q <= tick_cnt_d;
        end
    end

    // Frame FSM: next state, tick/bit counters, shift register and frame result strobes.
    always_comb begin
        state_d    = state_q;
        s_cnt_d    = s_cnt_q;
        n_d        = n_q;
        shreg_d    = shreg_q;
        push_s     = 1'b0;
        ferr_set_s = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_edge_s) begin
                    state_d = S_START;
                    s_cnt_d = '0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_START: begin
                if (tick_s) begin
                    if (s_cnt_q == START_MID) begin
                        s_cnt_d = '0;
                        if (sync2_q == 1'b0) begin
                            state_d = S_DATA;
                            n_d     = '0;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end else begin
                        s_cnt_d = s_cnt_q + SW'(1);
                    end
                end else begin
                    state_d = S_START;
                end
            end
            S_DATA: begin
                if (tick_s) begin
                    if (s_cnt_q == DATA_LAST) begin
                        s_cnt_d        = '0;
                        shreg_d[n_q]   = sync2_q;
                        if (n_q == N_LAST) begin
                            state_d = S_STOP;
                        end else begin
                            n_d = n_q + NW'(1);
                        end
                    end else begin
                        s_cnt_d = s_cnt_q + SW'(1);
                    end
                end else begin
                    state_d = S_DATA;
                end
            end
            S_STOP: begin
                if (tick_s) begin
                    if (s_cnt_q == STOP_LAST) begin
                        s_cnt_d = '0;
                        state_d = S_IDLE;
                        if (sync2_q) begin
                            push_s = 1'b1;
                        end else begin
                            ferr_set_s = 1'b1;
                        end
                    end else begin
                        s_cnt_d = s_cnt_q + SW'(1);
                    end
                end else begin
                    state_d = S_STOP;
                end
            end
            default: begin
                state_d = S_IDLE;
                s_cnt_d = '0;
                n_d     = '0;
            end
        endcase
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state_q <= S_IDLE;
            s_cnt_q <= '0;
            n_q     <= '0;
            shreg_q <= '0;
        end else begin
            state_q <= state_d;
            s_cnt_q <= s_cnt_d;
            n_q     <= n_d;
            shreg_q <= shreg_d;
        end
    end

    // A push into a full FIFO still succeeds when a pop frees the head slot in the same cycle.
    always_comb begin
        empty_s   = (count_q == '0);
        full_s    = (count_q == DEPTH_C);
        pop_s     = PREAD && !empty_s;
        wr_s      = push_s && (!full_s || pop_s);
        ovr_set_s = push_s && full_s && !pop_s;
        wptr_d    = wr_s ? (wptr_q + AW'(1)) : wptr_q;
        rptr_d    = pop_s ? (rptr_q + AW'(1)) : rptr_q;
        case ({wr_s, pop_s})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        if (ferr_set_s) begin
            ferr_d = 1'b1;
        end else if (clr_err) begin
            ferr_d = 1'b0;
        end else begin
            ferr_d = ferr_q;
        end
        if (ovr_set_s) begin
            ovr_d = 1'b1;
        end else if (clr_err) begin
            ovr_d = 1'b0;
        end else begin
            ovr_d = ovr_q;
        end
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            done_q  <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            if (wr_s) begin
                mem_q[wptr_q] <= shreg_q;
            end
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            done_q  <= push_s;
            ferr_q  <= ferr_d;
            ovr_q   <= ovr_d;
        end
    end

    assign rx_dout    = empty_s ? '0 : mem_q[rptr_q];
    assign rx_valid   = !empty_s;
    assign rx_done    = done_q;
    assign frame_err  = ferr_q;
    assign overrun    = ovr_q;
    assign fifo_count = count_q;

    uart_rx_fifo_chk #(
        .DBITS (DBITS),
        .CW    (CW),
        .DEPTH (FIFO_DEPTH)
    ) u_chk (
        .clk_i   (PCLK),
        .rst_i   (PRESET),
        .count_i (count_q),
        .valid_i (rx_valid),
        .dout_i  (rx_dout)
    );

endmodule

// Invariants of the receive FIFO output view.
module uart_rx_fifo_chk #(
    parameter int DBITS = 8,
    parameter int CW    = 3,
    parameter int DEPTH = 4
) (
    input logic             clk_i,
    input logic             rst_i,
    input logic [CW-1:0]    count_i,
    input logic             valid_i,
    input logic [DBITS-1:0] dout_i
);

    a_count_max: assert property (@(posedge clk_i) disable iff (rst_i)
        count_i <= CW'(DEPTH));

    a_valid_count: assert property (@(posedge clk_i) disable iff (rst_i)
        valid_i == (count_i != '0));

    a_empty_zero: assert property (@(posedge clk_i) disable iff (rst_i)
        !valid_i |-> (dout_i == '0));

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- Oversampling UART receiver: the receive end of the 8N1 serial link driven by the team's UART transmitter.
- Recovers frames from the asynchronous `rx` line using an internal 16x baud tick.
- Validates start and stop bits and buffers received bytes in a small first-word-fall-through (FWFT) FIFO.
- Offers the bytes to the bus side through a read-strobe interface, alongside the transmitter in the UART top.

Parameters:
- DBITS, 8, data bits per frame, LSB first.
- SB_TICK, 16, oversample ticks spanning the stop bit.
- CLOCK_RATE, 100000000, PCLK frequency in Hz.
- BAUD_RATE, 9600, line baud rate.
- FIFO_DEPTH, 4, receive FIFO entries (power of 2, >=2).

Ports:
- PCLK  input  1  system clock, all logic rising-edge.
- PRESET  input  1  asynchronous active-high reset.
- rx  input  1  serial line, idle high, asynchronous to PCLK.
- PREAD  input  1  pop strobe; one entry popped per cycle it is high and the FIFO is non-empty.
- clr_err  input  1  synchronous clear of the sticky error flags.
- rx_dout  output  DBITS  FIFO head byte; 0 when empty.
- rx_valid  output  1  FIFO non-empty.
- rx_done  output  1  one-cycle pulse per accepted frame.
- frame_err  output  1  sticky: stop bit sampled low.
- overrun  output  1  sticky: frame accepted while FIFO full and no simultaneous pop.
- fifo_count  output  $clog2(FIFO_DEPTH)+1  current occupancy.

Behaviour:
- Reset (async, PRESET=1):
  - state IDLE; all counters 0; FIFO empty.
  - Sync flops and previous-sample register preset to 1.
  - Outputs: rx_dout=0, rx_valid=0, rx_done=0, frame_err=0, overrun=0, fifo_count=0.
  - Reset mid-frame abandons the frame with no push.
- Synchroniser: rx passes through 2 flops; edge detection uses the synced value against its previous sample (3rd flop).
- Tick generator:
  - DIV = CLOCK_RATE/(BAUD_RATE*16), integer-truncated.
  - Free-running counter 0..DIV-1; tick is high for one cycle when counter = DIV-1.
  - Counter restarts at 0 on start-edge detection so sampling aligns to the edge.
- State machine (s_cnt = tick count, n = bit index):
  - IDLE: a falling edge (prev=1, cur=0) goes to START with s_cnt=0. A level stuck low never retriggers.
  - START: on tick, s_cnt++. At s_cnt=7 (mid start bit), sample:
    - 0: go to DATA with s_cnt=0, n=0.
    - 1: glitch; go to IDLE with no flag.
  - DATA: on tick, s_cnt++. At s_cnt=15, shift the sample into shreg[n] (LSB first) and set s_cnt=0. After n=DBITS-1 go to STOP, else n++.
  - STOP: on tick, s_cnt++. At s_cnt=SB_TICK-1, sample:
    - 1: push shreg and pulse rx_done.
    - 0: set frame_err, no push, no rx_done.
    - Either way, go to IDLE.
- Latency: rx_done, rx_valid, rx_dout and fifo_count update in the cycle after the stop-sample tick.
- FIFO (FWFT, circular pointers wrap modulo FIFO_DEPTH):
  - Pop when empty: ignored.
  - Push when full without pop: byte dropped, overrun set, rx_done still pulses, FIFO contents unchanged.
  - Push and pop in the same cycle: both performed. When full, no overrun and fifo_count is unchanged. When empty, the pushed byte becomes the head next cycle and count=1.
- Sticky flags: cleared by clr_err next cycle. Same-cycle set and clr_err: set wins.

Test Plan (CLOCK_RATE=1600000, BAUD_RATE=10000, so DIV=10 and a bit is 160 cycles):
- Single frame 0xA5, 8N1 ideal timing -> rx_done pulses once; rx_valid=1, rx_dout=0xA5, fifo_count=1; PREAD for one cycle -> rx_valid=0, rx_dout=0.
- rx low pulse of 50 cycles then high -> returns to IDLE; no rx_done, no frame_err, count stays 0.
- Frame 0x3C with the stop bit driven low -> frame_err=1, count=0, no rx_done; clr_err -> frame_err=0.
- Five frames 0x01..0x05 with no reads -> count=4, overrun=1; reads return 0x01,0x02,0x03,0x04 in order.
- FIFO full; 5th frame's stop sample coincides with a PREAD -> overrun=0, count stays 4, tail=0x05.
- PRESET asserted mid-DATA of frame 0xFF, released, then frame 0x5A sent -> only 0x5A received; all outputs 0 during reset.
